switch_debouncer: RTL
=====================

// Module: switch_debouncer
// PURPOSE
//  Conditions raw slide-switch inputs before they drive the counter's increment input.
//  Each bit gets a 2-FF synchronizer and an independent debounce counter.
//  The block outputs the debounced level, one-cycle rise and fall pulses per bit,
//  and a global "changed" pulse. It sits between the board switch pins and counter.increment.
// PARAMETERS
//  WIDTH            8       number of switch bits
//  DEBOUNCE_CYCLES  500000  cycles a new level must persist before it is accepted (10 ms @ 50 MHz); legal range >= 1
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (localparam, derived)
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  sw_in      in   WIDTH  raw asynchronous switch pins
//  sw_stable  out  WIDTH  debounced switch level (registered)
//  sw_rise    out  WIDTH  1-cycle pulse per bit on an accepted 0->1
//  sw_fall    out  WIDTH  1-cycle pulse per bit on an accepted 1->0
//  changed    out  1      1-cycle pulse when any bit of sw_stable changes
// BEHAVIOUR
//  Reset (rst=1 at posedge): sync1, sync2, sw_stable, all counters, sw_rise, sw_fall and changed clear to 0.
//  Synchronizer: sync1 <= sw_in; sync2 <= sync1. Only sync2 is used downstream.
//  Per-bit state is implicit: IDLE when sync2[i]==sw_stable[i], otherwise SETTLING.
//  Per-bit update each cycle:
//   - sync2[i]==sw_stable[i]: cnt[i] <= 0 (a bounce back aborts settling).
//   - sync2[i]!=sw_stable[i] and cnt[i]==DEBOUNCE_CYCLES-1: sw_stable[i] <= sync2[i] and cnt[i] <= 0.
//     In the same cycle, the rise or fall bit for i <= 1.
//   - otherwise: cnt[i] <= cnt[i]+1.
//  sw_rise, sw_fall and changed are registered. They assert in the same cycle sw_stable changes and are 0 otherwise.
//  changed = OR of (sw_rise | sw_fall), registered alongside them.
//  Latency: sw_in is first sampled at edge k and then held steady. sw_stable changes on edge k+DEBOUNCE_CYCLES+1,
//   i.e. it is visible DEBOUNCE_CYCLES+2 edges after the sampling edge counting edge k.
//  Glitch rejection: if the level persists for fewer than DEBOUNCE_CYCLES consecutive sync2 cycles,
//   sw_stable is not changed.
//  Bits are fully independent. Simultaneous acceptance on several bits yields several pulse bits in one cycle
//   and a single changed pulse.
//  The counter never wraps: it holds at most DEBOUNCE_CYCLES-1 and clears on acceptance or abort.
//  Reset mid-settling discards progress. Switches high at reset release produce sw_rise
//   after DEBOUNCE_CYCLES+2 edges, as a normal change does.
//  DEBOUNCE_CYCLES==1: a new sync2 level is accepted on the first edge on which it differs.
// TESTING  (bench uses WIDTH=8, DEBOUNCE_CYCLES=4)
//  1. Reset check: hold rst for 3 cycles with sw_in=8'hFF.
//     -> Every output is 0 during reset.
//     -> After release, sw_stable becomes 8'hFF exactly 6 edges after the first sampling edge.
//     -> sw_rise=8'hFF and changed=1 for exactly that one cycle.
//  2. Steady 0->1 on bit 0, sw_in 8'h00->8'h01 held.
//     -> sw_stable=8'h01 after 6 edges, sw_rise=8'h01 for 1 cycle, sw_fall=0.
//  3. Bounce on bit 3: toggle 1,0,1,0 every cycle, then hold 1.
//     -> No change during the bounce.
//     -> sw_stable[3]=1 exactly 6 edges after the last sampled transition.
//  4. Short glitch: bit 5 high for 3 cycles, then back low.
//     -> sw_stable, sw_rise and changed stay 0 throughout.
//  5. Simultaneous events: bits 1 and 6 rise while bit 0 falls, all on the same cycle.
//     -> One cycle with sw_rise=8'h42, sw_fall=8'h01 and a single changed pulse.
//  6. Reset mid-settling: sw_in 8'h00->8'h80, then assert rst 2 cycles later.
//     -> sw_stable stays 0.
//     -> After release, acceptance takes the full 6 edges from the first post-reset sampling edge.

Source files
------------

// File: rtl/switch_debouncer_if.sv
// rtl/switch_debouncer_if.sv - switch pins in, debounced level and edge pulses out
interface switch_debouncer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             changed;

  // master drives the raw pins, slave is the debouncer
  modport master (
    output sw_in,
    input  sw_stable,
    input  sw_rise,
    input  sw_fall,
    input  changed
  );

  modport slave (
    input  sw_in,
    output sw_stable,
    output sw_rise,
    output sw_fall,
    output changed
  );
endinterface

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-bit 2-FF synchronizer plus persistence counter debouncer
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic               clk,
  input logic               rst,
  switch_debouncer_if.slave bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] sw_stable_q, sw_stable_d;
  logic [WIDTH-1:0] sw_rise_q, sw_rise_d;
  logic [WIDTH-1:0] sw_fall_q, sw_fall_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // A bit is settling while its synchronized level disagrees with the accepted one;
  // any return to agreement throws the partial count away.
  always_comb begin
    sw_stable_d = sw_stable_q;
    sw_rise_d   = '0;
    sw_fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == sw_stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        sw_stable_d[i] = sync2_q[i];
        sw_rise_d[i]   = sync2_q[i];
        sw_fall_d[i]   = ~sync2_q[i];
        cnt_d[i]       = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    changed_d = |(sw_rise_d | sw_fall_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sw_stable_q <= '0;
      sw_rise_q   <= '0;
      sw_fall_q   <= '0;
      changed_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= bus.sw_in;
      sync2_q     <= sync1_q;
      sw_stable_q <= sw_stable_d;
      sw_rise_q   <= sw_rise_d;
      sw_fall_q   <= sw_fall_d;
      changed_q   <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.sw_stable = sw_stable_q;
  assign bus.sw_rise   = sw_rise_q;
  assign bus.sw_fall   = sw_fall_q;
  assign bus.changed   = changed_q;
endmodule
